timing_seq_p: RTL and testbench

- Parametrised T-state sequencer for the 65xx core; successor to the fixed 3-bit, 8-state timing controller.
- Consumes the microcode next-state hint plus ALU, branch and decoder flags, and produces the current and next T-state.
- New over the fixed controller: configurable state count, uniform early-exit rules in every execute state, interrupt entry sequencing, per-instruction cycle counting, and sticky sequence-overrun detection.

---
 rtl/timing_seq_p_if.sv | 34 +++
 rtl/timing_seq_p.sv | 72 +++++++
 tb/tb_timing_seq_p.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/timing_seq_p_if.sv
// timing_seq_p_if: flag inputs and state outputs of the T-state sequencer
interface timing_seq_p_if #(
  parameter int TW = 3,
  parameter int CW = 4
);
  logic          ready;
  logic [2:0]    tnext_mc;
  logic          alu_carry_out;
  logic          taken_branch;
  logic          branch_page_cross;
  logic          onecycle;
  logic          twocycle;
  logic          dec_cycle;
  logic          dec_extra_cycle;
  logic          int_req;
  logic [TW-1:0] t;
  logic [TW-1:0] t_next;
  logic          sync;
  logic          int_ack;
  logic          insn_done;
  logic [CW-1:0] cyc_count;
  logic [CW-1:0] last_cycles;
  logic          seq_err;
  modport master (
    output ready, tnext_mc, alu_carry_out, taken_branch, branch_page_cross,
           onecycle, twocycle, dec_cycle, dec_extra_cycle, int_req,
    input  t, t_next, sync, int_ack, insn_done, cyc_count, last_cycles, seq_err
  );
  modport slave (
    input  ready, tnext_mc, alu_carry_out, taken_branch, branch_page_cross,
           onecycle, twocycle, dec_cycle, dec_extra_cycle, int_req,
    output t, t_next, sync, int_ack, insn_done, cyc_count, last_cycles, seq_err
  );
endinterface

// File: rtl/timing_seq_p.sv
// timing_seq_p: parametrised 65xx T-state sequencer with interrupt entry, cycle counting and overrun flag
module timing_seq_p #(
  parameter int TW      = 3,
  parameter int MAXT    = 7,
  parameter int RESET_T = 2,
  parameter int CW      = 4
) (
  input logic          clk,
  input logic          reset,
  timing_seq_p_if.slave bus
);
  typedef enum logic [2:0] {H_ADV, H_END, H_TNC, H_TBR, H_TBE, H_TBT} hint_t;
  localparam logic [TW-1:0] T0     = '0;
  localparam logic [TW-1:0] T1     = TW'(1);
  localparam logic [TW-1:0] T2     = TW'(2);
  localparam logic [TW-1:0] TD     = TW'(MAXT);
  localparam logic [TW-1:0] T_LAST = TW'(MAXT - 1);
  localparam logic [TW-1:0] T_RST  = TW'(RESET_T);
  logic [TW-1:0] r_t, w_t_next;
  logic [CW-1:0] r_cyc, r_last, w_cyc_inc;
  logic          r_int_pend, r_int_ack, r_err, w_wrap;
  assign w_cyc_inc = &r_cyc ? r_cyc : r_cyc + 1'b1;
  // next-state selection; w_wrap marks a microcode overrun forced back to T0
  always_comb begin
    w_wrap   = 1'b0;
    w_t_next = T0;
    if (r_t == T0)
      w_t_next = T1;
    else if (r_t == T1)
      w_t_next = r_int_pend ? T2 : bus.onecycle ? T1 : bus.dec_cycle ? TD : bus.twocycle ? T0 : T2;
    else if (r_t == TD)
      w_t_next = bus.dec_extra_cycle ? T2 : T0;
    else if (r_t < TD) begin
      if (bus.tnext_mc == H_END || (bus.tnext_mc == H_TNC && !bus.alu_carry_out))
        w_t_next = T0;
      else if ((bus.tnext_mc == H_TBR && !bus.taken_branch) || (bus.tnext_mc == H_TBT && !bus.alu_carry_out))
        w_t_next = T1;
      else if (bus.tnext_mc == H_TBE)
        w_t_next = bus.branch_page_cross ? T0 : T1;
      else if (r_t == T_LAST) begin
        w_t_next = T0;
        w_wrap   = 1'b1;
      end else
        w_t_next = r_t + 1'b1;
    end
  end
  // state, interrupt entry, cycle counters and sticky overrun; all frozen while not ready
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_t        <= T_RST;
      r_int_pend <= 1'b0;
      r_int_ack  <= 1'b0;
      r_cyc      <= '0;
      r_last     <= '0;
      r_err      <= 1'b0;
    end else if (bus.ready) begin
      r_t        <= w_t_next;
      r_int_pend <= (r_t == T1) ? 1'b0 : (r_t == T0 && bus.int_req) ? 1'b1 : r_int_pend;
      r_int_ack  <= r_t == T1 && r_int_pend;
      r_err      <= r_err | w_wrap;
      r_cyc      <= (w_t_next == T1) ? '0 : w_cyc_inc;
      if (w_t_next == T1) r_last <= w_cyc_inc;
    end
  assign bus.t           = r_t;
  assign bus.t_next      = w_t_next;
  assign bus.sync        = r_t == T1;
  assign bus.int_ack     = r_int_ack;
  assign bus.insn_done   = bus.ready && w_t_next == T1;
  assign bus.cyc_count   = r_cyc;
  assign bus.last_cycles = r_last;
  assign bus.seq_err     = r_err;
endmodule

// File: tb/tb_timing_seq_p.sv
// tb_timing_seq_p: table-driven directed vectors for the T-state sequencer
module tb_timing_seq_p;
  localparam logic [7:0] C = 1, TK = 2, PC = 4, OC = 8, TC = 16, DC = 32, DX = 64, IR = 128;
  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [2:0] mc;
    logic [7:0] f;
    logic [2:0] tn;
    logic [2:0] t;
    logic [3:0] cyc;
    logic [3:0] last;
    logic       err;
    logic       ack;
  } vec_t;
  logic clk, reset;
  int total = 0, bad = 0;
  vec_t q[$];
  timing_seq_p_if bus ();
  timing_seq_p dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rst, input logic rdy, input logic [2:0] mc, input logic [7:0] f,
                              input logic [2:0] tn, input logic [2:0] t, input logic [3:0] cyc,
                              input logic [3:0] last, input logic err, input logic ack);
    return '{rst, rdy, mc, f, tn, t, cyc, last, err, ack};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, a, e);
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, " t"}, bus.t, 2);
    chk({n, " cyc"}, bus.cyc_count, 0);
    chk({n, " last"}, bus.last_cycles, 0);
    chk({n, " err"}, bus.seq_err, 0);
    chk({n, " ack"}, bus.int_ack, 0);
  endtask
  task automatic pulse_reset(input string n);
    reset = 1'b1;
    #2;
    chk_reset(n);
    reset = 1'b0;
    #1;
  endtask
  task automatic apply(input vec_t v, input int i);
    if (v.rst) pulse_reset($sformatf("v%0d rst", i));
    bus.ready = v.rdy;
    bus.tnext_mc = v.mc;
    {bus.int_req, bus.dec_extra_cycle, bus.dec_cycle, bus.twocycle, bus.onecycle,
     bus.branch_page_cross, bus.taken_branch, bus.alu_carry_out} = v.f;
    #1;
    chk($sformatf("v%0d t_next", i), bus.t_next, v.tn);
    chk($sformatf("v%0d insn_done", i), bus.insn_done, v.rdy && v.tn == 3'd1);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d t", i), bus.t, v.t);
    chk($sformatf("v%0d sync", i), bus.sync, v.t == 3'd1);
    chk($sformatf("v%0d cyc", i), bus.cyc_count, v.cyc);
    chk($sformatf("v%0d last", i), bus.last_cycles, v.last);
    chk($sformatf("v%0d err", i), bus.seq_err, v.err);
    chk($sformatf("v%0d ack", i), bus.int_ack, v.ack);
  endtask
  initial begin
    // reset release, free-running ADV overruns at T6
    q.push_back(mk(0,1,0,0,  3,3,1,0,0,0));
    q.push_back(mk(0,1,0,0,  4,4,2,0,0,0));
    q.push_back(mk(0,1,0,0,  5,5,3,0,0,0));
    q.push_back(mk(0,1,0,0,  6,6,4,0,0,0));
    q.push_back(mk(0,1,0,0,  0,0,5,0,1,0));
    q.push_back(mk(0,1,0,0,  1,1,0,6,1,0));
    // fresh reset, END at T2
    q.push_back(mk(1,1,1,0,  0,0,1,0,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,2,0,0));
    // two-cycle opcode
    q.push_back(mk(0,1,0,TC, 0,0,1,2,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,2,0,0));
    // branch not taken
    q.push_back(mk(0,1,0,0,  2,2,1,2,0,0));
    q.push_back(mk(0,1,3,0,  1,1,0,2,0,0));
    // branch taken, same page
    q.push_back(mk(0,1,0,0,  2,2,1,2,0,0));
    q.push_back(mk(0,1,3,TK, 3,3,2,2,0,0));
    q.push_back(mk(0,1,4,0,  1,1,0,3,0,0));
    // branch taken, page cross
    q.push_back(mk(0,1,0,0,  2,2,1,3,0,0));
    q.push_back(mk(0,1,3,TK, 3,3,2,3,0,0));
    q.push_back(mk(0,1,4,PC, 0,0,3,3,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,4,0,0));
    // indexed read, no carry
    q.push_back(mk(0,1,0,0,  2,2,1,4,0,0));
    q.push_back(mk(0,1,0,0,  3,3,2,4,0,0));
    q.push_back(mk(0,1,2,0,  0,0,3,4,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,4,0,0));
    // indexed read, carry
    q.push_back(mk(0,1,0,0,  2,2,1,4,0,0));
    q.push_back(mk(0,1,0,0,  3,3,2,4,0,0));
    q.push_back(mk(0,1,2,C,  4,4,3,4,0,0));
    q.push_back(mk(0,1,1,0,  0,0,4,4,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,5,0,0));
    // TBT without carry
    q.push_back(mk(0,1,0,0,  2,2,1,5,0,0));
    q.push_back(mk(0,1,5,0,  1,1,0,2,0,0));
    // decimal adjust with extra cycle
    q.push_back(mk(0,1,0,DC, 7,7,1,2,0,0));
    q.push_back(mk(0,1,0,DX, 2,2,2,2,0,0));
    q.push_back(mk(0,1,1,0,  0,0,3,2,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,4,0,0));
    // ready low freezes a onecycle loop
    q.push_back(mk(0,0,0,OC, 1,1,0,4,0,0));
    q.push_back(mk(0,0,0,OC, 1,1,0,4,0,0));
    q.push_back(mk(0,0,0,OC, 1,1,0,4,0,0));
    q.push_back(mk(0,1,0,OC, 1,1,0,1,0,0));
    // interrupt latched at T0 overrides onecycle at T1
    q.push_back(mk(0,1,0,TC, 0,0,1,1,0,0));
    q.push_back(mk(0,1,0,IR, 1,1,0,2,0,0));
    q.push_back(mk(0,1,0,OC, 2,2,1,2,0,1));
    q.push_back(mk(0,0,0,0,  3,2,1,2,0,1));
    q.push_back(mk(0,1,0,0,  3,3,2,2,0,0));
    // int_req outside T0 ignored
    q.push_back(mk(0,1,0,IR, 4,4,3,2,0,0));
    q.push_back(mk(0,1,1,0,  0,0,4,2,0,0));
    q.push_back(mk(0,1,0,0,  1,1,0,5,0,0));
    q.push_back(mk(0,1,0,OC, 1,1,0,1,0,0));
    reset = 1'b1;
    bus.ready = 1'b1;
    bus.tnext_mc = 3'd0;
    {bus.int_req, bus.dec_extra_cycle, bus.dec_cycle, bus.twocycle, bus.onecycle,
     bus.branch_page_cross, bus.taken_branch, bus.alu_carry_out} = 8'd0;
    #1;
    chk_reset("por");
    @(posedge clk);
    #1;
    chk_reset("por hold");
    reset = 1'b0;
    foreach (q[i]) apply(q[i], i);
    // walk to T4, then abort asynchronously mid-instruction
    apply(mk(0,1,0,0, 2,2,1,1,0,0), 100);
    apply(mk(0,1,0,0, 3,3,2,1,0,0), 101);
    apply(mk(0,1,0,0, 4,4,3,1,0,0), 102);
    pulse_reset("abort at T4");
    apply(mk(0,1,0,0, 3,3,1,0,0,0), 103);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
